// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int DATA_W          = 32;
    localparam int REG_W           = 5;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register; a bubble loads all zeros instead of the inputs.
module mem_wb
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [REG_W-1:0]  dst,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [DATA_W-1:0] memdata_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  mux_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bubble) begin
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            memdata_out  <= '0;
            alu_out      <= '0;
            mux_out      <= '0;
        end else begin
            RegWrite_out <= reg_write;
            MemtoReg_out <= mem_to_reg;
            memdata_out  <= mem_data;
            alu_out      <= alu_result;
            mux_out      <= dst;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-memory requests, stalls upstream while waiting,
// aborts on misalignment or timeout, and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] readdata2,
    input  logic [REG_W-1:0]  mux,
    mem_stage_if.master       dmem,
    output logic              stall,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [DATA_W-1:0] memdata_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  mux_out,
    output logic              err_misalign,
    output logic              err_timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state;
    logic [CW-1:0]      count;
    logic               cap_reg_write;
    logic               cap_mem_to_reg;
    logic [REG_W-1:0]   cap_dst;

    logic               access;
    logic               misaligned;
    logic               last_wait;
    logic               wb_bubble;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;
    logic [DATA_W-1:0]  wb_mem_data;
    logic [DATA_W-1:0]  wb_alu;
    logic [REG_W-1:0]   wb_dst;

    assign access     = MemRead | MemWrite;
    assign misaligned = (alu[1:0] != 2'b00);
    assign last_wait  = (count == CW'(TIMEOUT - 1));

    // Anything other than a plain ALU op or a completing access sends a bubble.
    always_comb begin
        stall         = 1'b0;
        wb_bubble     = 1'b1;
        wb_reg_write  = 1'b0;
        wb_mem_to_reg = 1'b0;
        wb_mem_data   = '0;
        wb_alu        = '0;
        wb_dst        = '0;
        if (rst) begin
            if (state == IDLE) begin
                if (!access) begin
                    wb_bubble     = 1'b0;
                    wb_reg_write  = RegWrite;
                    wb_mem_to_reg = MemtoReg;
                    wb_alu        = alu;
                    wb_dst        = mux;
                end else if (!misaligned) begin
                    stall = 1'b1;
                end
            end else begin
                if (dmem.dmem_ack) begin
                    wb_bubble     = 1'b0;
                    wb_reg_write  = cap_reg_write;
                    wb_mem_to_reg = cap_mem_to_reg;
                    wb_mem_data   = dmem.dmem_we ? '0 : dmem.dmem_rdata;
                    wb_alu        = dmem.dmem_addr;
                    wb_dst        = cap_dst;
                end else if (!last_wait) begin
                    stall = 1'b1;
                end
            end
        end
    end

    // Request FSM; the bus fields are captured once and held for the whole WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            count           <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            cap_reg_write   <= 1'b0;
            cap_mem_to_reg  <= 1'b0;
            cap_dst         <= '0;
            err_misalign    <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            if (state == IDLE) begin
                if (access && misaligned) begin
                    err_misalign <= 1'b1;
                end else if (access) begin
                    state           <= WAIT;
                    count           <= '0;
                    dmem.dmem_req   <= 1'b1;
                    dmem.dmem_we    <= MemWrite;
                    dmem.dmem_addr  <= alu;
                    dmem.dmem_wdata <= readdata2;
                    cap_reg_write   <= RegWrite;
                    cap_mem_to_reg  <= MemtoReg;
                    cap_dst         <= mux;
                end
            end else begin
                if (dmem.dmem_ack) begin
                    state         <= IDLE;
                    dmem.dmem_req <= 1'b0;
                end else if (last_wait) begin
                    state         <= IDLE;
                    dmem.dmem_req <= 1'b0;
                    err_timeout   <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    mem_wb u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .bubble       (wb_bubble),
        .reg_write    (wb_reg_write),
        .mem_to_reg   (wb_mem_to_reg),
        .mem_data     (wb_mem_data),
        .alu_result   (wb_alu),
        .dst          (wb_dst),
        .RegWrite_out (RegWrite_out),
        .MemtoReg_out (MemtoReg_out),
        .memdata_out  (memdata_out),
        .alu_out      (alu_out),
        .mux_out      (mux_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; memory responses are driven by hand.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic              clk;
    logic              rst;
    logic              MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0]       alu, readdata2;
    logic [4:0]        mux;
    logic              stall;
    logic              RegWrite_out, MemtoReg_out;
    logic [31:0]       memdata_out, alu_out;
    logic [4:0]        mux_out;
    logic              err_misalign, err_timeout;

    int compared;
    int mismatched;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .alu          (alu),
        .readdata2    (readdata2),
        .mux          (mux),
        .dmem         (bus),
        .stall        (stall),
        .RegWrite_out (RegWrite_out),
        .MemtoReg_out (MemtoReg_out),
        .memdata_out  (memdata_out),
        .alu_out      (alu_out),
        .mux_out      (mux_out),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
        alu = 32'h0; readdata2 = 32'h0; mux = 5'd0;
    endtask

    task automatic test_reset();
        MemRead = 1; RegWrite = 1; alu = 32'h40; mux = 5'd4;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %0b want 0", stall); end
        compared++; if (bus.dmem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req: got %0b want 0", bus.dmem_req); end
        compared++; if (bus.dmem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h want 0", bus.dmem_addr); end
        compared++; if (RegWrite_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_regwrite: got %0b want 0", RegWrite_out); end
        compared++; if (alu_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_alu_out: got %h want 0", alu_out); end
        compared++; if ({err_misalign, err_timeout} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_err: got %b want 00", {err_misalign, err_timeout}); end
        idle_inputs();
    endtask

    task automatic test_alu_only();
        @(negedge clk);
        idle_inputs();
        RegWrite = 1; alu = 32'h10; mux = 5'd3; readdata2 = 32'h5555;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL alu_stall: got %0b want 0", stall); end
        @(posedge clk); @(negedge clk);
        compared++; if (RegWrite_out !== 1'b1) begin mismatched++; $display("[TB] FAIL alu_regwrite: got %0b want 1", RegWrite_out); end
        compared++; if (alu_out !== 32'h10) begin mismatched++; $display("[TB] FAIL alu_alu_out: got %h want 10", alu_out); end
        compared++; if (mux_out !== 5'd3) begin mismatched++; $display("[TB] FAIL alu_mux_out: got %0d want 3", mux_out); end
        compared++; if (memdata_out !== 32'h0) begin mismatched++; $display("[TB] FAIL alu_memdata: got %h want 0", memdata_out); end
        compared++; if (bus.dmem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL alu_req: got %0b want 0", bus.dmem_req); end
        idle_inputs();
    endtask

    task automatic test_load();
        int stall_cycles;
        stall_cycles = 0;
        @(negedge clk);
        MemRead = 1; MemtoReg = 1; RegWrite = 1; alu = 32'h20; mux = 5'd7;
        #1;
        if (stall) stall_cycles++;
        @(posedge clk); @(negedge clk);
        compared++; if (bus.dmem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL load_req: got %0b want 1", bus.dmem_req); end
        compared++; if (bus.dmem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL load_we: got %0b want 0", bus.dmem_we); end
        compared++; if (bus.dmem_addr !== 32'h20) begin mismatched++; $display("[TB] FAIL load_addr: got %h want 20", bus.dmem_addr); end
        compared++; if (RegWrite_out !== 1'b0) begin mismatched++; $display("[TB] FAIL load_bubble: got %0b want 0", RegWrite_out); end
        bus.dmem_ack = 1; bus.dmem_rdata = 32'hDEADBEEF;
        #1;
        if (stall) stall_cycles++;
        @(posedge clk); @(negedge clk);
        bus.dmem_ack = 0;
        idle_inputs();
        compared++; if (stall_cycles !== 1) begin mismatched++; $display("[TB] FAIL load_stall_cycles: got %0d want 1", stall_cycles); end
        compared++; if (memdata_out !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL load_memdata: got %h want deadbeef", memdata_out); end
        compared++; if (mux_out !== 5'd7) begin mismatched++; $display("[TB] FAIL load_mux_out: got %0d want 7", mux_out); end
        compared++; if ({RegWrite_out, MemtoReg_out} !== 2'b11) begin mismatched++; $display("[TB] FAIL load_ctrl: got %b want 11", {RegWrite_out, MemtoReg_out}); end
        compared++; if (alu_out !== 32'h20) begin mismatched++; $display("[TB] FAIL load_alu_out: got %h want 20", alu_out); end
        compared++; if (bus.dmem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL load_req_drop: got %0b want 0", bus.dmem_req); end
    endtask

    task automatic test_store();
        int stall_cycles;
        stall_cycles = 0;
        @(negedge clk);
        MemWrite = 1; alu = 32'h44; readdata2 = 32'h1234; mux = 5'd2;
        #1;
        if (stall) stall_cycles++;
        @(posedge clk);
        for (int w = 1; w <= 5; w++) begin
            @(negedge clk);
            compared++; if ({bus.dmem_req, bus.dmem_we} !== 2'b11) begin mismatched++; $display("[TB] FAIL store_req_we c%0d: got %b want 11", w, {bus.dmem_req, bus.dmem_we}); end
            compared++; if (bus.dmem_addr !== 32'h44 || bus.dmem_wdata !== 32'h1234) begin mismatched++; $display("[TB] FAIL store_bus c%0d: got %h/%h want 44/1234", w, bus.dmem_addr, bus.dmem_wdata); end
            if (w == 5) begin bus.dmem_ack = 1; bus.dmem_rdata = 32'h77777777; end
            #1;
            if (stall) stall_cycles++;
            @(posedge clk);
        end
        @(negedge clk);
        bus.dmem_ack = 0;
        idle_inputs();
        compared++; if (stall_cycles !== 5) begin mismatched++; $display("[TB] FAIL store_stall_cycles: got %0d want 5", stall_cycles); end
        compared++; if (RegWrite_out !== 1'b0) begin mismatched++; $display("[TB] FAIL store_regwrite: got %0b want 0", RegWrite_out); end
        compared++; if (memdata_out !== 32'h0) begin mismatched++; $display("[TB] FAIL store_memdata: got %h want 0", memdata_out); end
        compared++; if (alu_out !== 32'h44) begin mismatched++; $display("[TB] FAIL store_alu_out: got %h want 44", alu_out); end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        MemRead = 1; MemtoReg = 1; RegWrite = 1; alu = 32'h21; mux = 5'd5;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_stall: got %0b want 0", stall); end
        @(posedge clk); @(negedge clk);
        idle_inputs();
        compared++; if (err_misalign !== 1'b1) begin mismatched++; $display("[TB] FAIL mis_err: got %0b want 1", err_misalign); end
        compared++; if (bus.dmem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_req: got %0b want 0", bus.dmem_req); end
        compared++; if ({RegWrite_out, MemtoReg_out, mux_out} !== 7'd0 || alu_out !== 32'h0) begin mismatched++; $display("[TB] FAIL mis_bubble: got %b/%0d/%h want zeros", RegWrite_out, mux_out, alu_out); end
        @(posedge clk); @(negedge clk);
        compared++; if (err_misalign !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_err_pulse: got %0b want 0", err_misalign); end
        compared++; if (bus.dmem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_req_late: got %0b want 0", bus.dmem_req); end
    endtask

    // with_ack: drive ack in the 16th WAIT cycle, which must win over the timeout
    task automatic test_timeout(input bit with_ack);
        int  req_cycles;
        logic last_stall;
        req_cycles = 0;
        last_stall = 1'b1;
        @(negedge clk);
        MemRead = 1; RegWrite = 1; alu = 32'h30; mux = 5'd11;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.dmem_req) break;
            req_cycles++;
            if (with_ack && req_cycles == 16) begin bus.dmem_ack = 1; bus.dmem_rdata = 32'hCAFEF00D; end
            #1;
            last_stall = stall;
            @(posedge clk);
        end
        bus.dmem_ack = 0;
        idle_inputs();
        compared++; if (req_cycles !== 16) begin mismatched++; $display("[TB] FAIL to%0d_req_cycles: got %0d want 16", with_ack, req_cycles); end
        compared++; if (last_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL to%0d_last_stall: got %0b want 0", with_ack, last_stall); end
        if (!with_ack) begin
            compared++; if (err_timeout !== 1'b1) begin mismatched++; $display("[TB] FAIL to_err: got %0b want 1", err_timeout); end
            compared++; if (RegWrite_out !== 1'b0) begin mismatched++; $display("[TB] FAIL to_bubble: got %0b want 0", RegWrite_out); end
        end else begin
            compared++; if (err_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL toack_err: got %0b want 0", err_timeout); end
            compared++; if (memdata_out !== 32'hCAFEF00D || mux_out !== 5'd11) begin mismatched++; $display("[TB] FAIL toack_data: got %h/%0d want cafef00d/11", memdata_out, mux_out); end
        end
        @(posedge clk); @(negedge clk);
        compared++; if (err_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL to%0d_err_pulse: got %0b want 0", with_ack, err_timeout); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        MemRead = 1; MemtoReg = 1; RegWrite = 1; alu = 32'h50; mux = 5'd9;
        @(posedge clk); @(negedge clk);
        bus.dmem_ack = 1; bus.dmem_rdata = 32'h11223344;
        @(posedge clk); @(negedge clk);
        bus.dmem_ack = 0;
        idle_inputs();
        MemWrite = 1; alu = 32'h54; readdata2 = 32'hA5A5A5A5;
        #1;
        compared++; if ({stall, bus.dmem_req} !== 2'b10) begin mismatched++; $display("[TB] FAIL b2b_start: got stall/req %b want 10", {stall, bus.dmem_req}); end
        compared++; if (memdata_out !== 32'h11223344 || mux_out !== 5'd9) begin mismatched++; $display("[TB] FAIL b2b_first: got %h/%0d want 11223344/9", memdata_out, mux_out); end
        @(posedge clk); @(negedge clk);
        compared++; if ({bus.dmem_req, bus.dmem_we} !== 2'b11 || bus.dmem_addr !== 32'h54 || bus.dmem_wdata !== 32'hA5A5A5A5) begin mismatched++; $display("[TB] FAIL b2b_second_req: got %b %h %h want 11 54 a5a5a5a5", {bus.dmem_req, bus.dmem_we}, bus.dmem_addr, bus.dmem_wdata); end
        bus.dmem_ack = 1;
        @(posedge clk); @(negedge clk);
        bus.dmem_ack = 0;
        idle_inputs();
        compared++; if (bus.dmem_req !== 1'b0 || alu_out !== 32'h54 || RegWrite_out !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_second_done: got req %0b alu_out %h rw %0b want 0 54 0", bus.dmem_req, alu_out, RegWrite_out); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        MemRead = 1; RegWrite = 1; MemtoReg = 1; alu = 32'h60; mux = 5'd6;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        compared++; if (bus.dmem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_wait_req: got %0b want 1", bus.dmem_req); end
        rst = 0;
        #1;
        compared++; if ({bus.dmem_req, bus.dmem_we, stall} !== 3'b000 || bus.dmem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_wait_clear: got req/we/stall %b addr %h want 000 0", {bus.dmem_req, bus.dmem_we, stall}, bus.dmem_addr); end
        compared++; if (err_timeout !== 1'b0 || RegWrite_out !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_wait_out: got err %0b rw %0b want 0 0", err_timeout, RegWrite_out); end
        @(posedge clk); @(negedge clk);
        rst = 1;
        idle_inputs();
        bus.dmem_ack = 1; bus.dmem_rdata = 32'h00000BAD;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL late_ack_stall: got %0b want 0", stall); end
        @(posedge clk); @(negedge clk);
        bus.dmem_ack = 0;
        compared++; if (bus.dmem_req !== 1'b0 || memdata_out !== 32'h0 || RegWrite_out !== 1'b0 || err_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL late_ack_ignored: got req %0b mem %h rw %0b err %0b want 0 0 0 0", bus.dmem_req, memdata_out, RegWrite_out, err_timeout); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 0;
        idle_inputs();
        bus.dmem_ack   = 0;
        bus.dmem_rdata = 32'h0;
        #2;
        test_reset();
        @(negedge clk);
        rst = 1;
        test_alu_only();
        test_load();
        test_store();
        test_misaligned();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
